// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debounce / pulse generator.
//   state_t : debounce FSM state encoding
//   EVT_W   : width of the optional rising-event counter
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  localparam int EVT_W = 8;

endpackage

// File: rtl/debounce_pulse_gen_sync_2ff.sv
// Two-flop synchroniser for one asynchronous level.
// Ports:
//   Clk      - system clock
//   Reset_n  - asynchronous active-low reset (both flops clear to 0)
//   AsyncIn  - raw asynchronous input
//   SyncOut  - input resynchronised to Clk, two cycles of latency
module sync_2ff (
  input  logic Clk,
  input  logic Reset_n,
  input  logic AsyncIn,
  output logic SyncOut
);

  logic stage1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stage1  <= 1'b0;
      SyncOut <= 1'b0;
    end else begin
      stage1  <= AsyncIn;
      SyncOut <= stage1;
    end
  end

endmodule

// File: rtl/debounce_pulse_gen.sv
// Debounce a bouncy switch level and produce a clean level plus edge strobes.
// Optional build macro: DEBOUNCE_EVT_CNT_EN adds the Evt_count output.
// Ports:
//   Clk       - system clock
//   Reset_n   - asynchronous active-low reset
//   Btn_in    - raw asynchronous switch/button level
//   D         - debounced level (registered)
//   E         - one-cycle strobe when D goes 0->1 (registered)
//   Fall      - one-cycle strobe when D goes 1->0 (registered)
//   Busy      - high while a candidate level change is being qualified
//   Evt_count - rising-event counter, wraps 255->0 (DEBOUNCE_EVT_CNT_EN only)
//
// state  | meaning
// S_LOW  | settled low, D=0
// S_RISE | sync input high, counting toward acceptance of a 1
// S_HIGH | settled high, D=1
// S_FALL | sync input low, counting toward acceptance of a 0
module debounce_pulse_gen
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Btn_in,
  output logic             D,
  output logic             E,
  output logic             Fall,
  output logic             Busy
`ifdef DEBOUNCE_EVT_CNT_EN
  ,
  output logic [EVT_W-1:0] Evt_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] stableCnt;
  logic             syncQ;

  sync_2ff uSync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .AsyncIn (Btn_in),
    .SyncOut (syncQ)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_LOW;
      stableCnt <= '0;
      D         <= 1'b0;
      E         <= 1'b0;
      Fall      <= 1'b0;
`ifdef DEBOUNCE_EVT_CNT_EN
      Evt_count <= '0;
`endif
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      E    <= 1'b0;
      Fall <= 1'b0;
      case (state)
        S_LOW: begin
          if (syncQ) begin
            state     <= S_RISE;
            stableCnt <= '0;
          end
        end
        S_RISE: begin
          if (!syncQ) begin
            state     <= S_LOW;
            stableCnt <= '0;
          end else if (stableCnt == CNT_LAST) begin
            state     <= S_HIGH;
            stableCnt <= '0;
            D         <= 1'b1;
            E         <= 1'b1;
`ifdef DEBOUNCE_EVT_CNT_EN
            Evt_count <= Evt_count + EVT_W'(1);
`endif
          end else begin
            stableCnt <= stableCnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!syncQ) begin
            state     <= S_FALL;
            stableCnt <= '0;
          end
        end
        S_FALL: begin
          if (syncQ) begin
            state     <= S_HIGH;
            stableCnt <= '0;
          end else if (stableCnt == CNT_LAST) begin
            state     <= S_LOW;
            stableCnt <= '0;
            D         <= 1'b0;
            Fall      <= 1'b1;
          end else begin
            stableCnt <= stableCnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_LOW;
          stableCnt <= '0;
        end
      endcase
    end
  end

  assign Busy = (state == S_RISE) || (state == S_FALL);

endmodule
